// File: rtl/code_rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : code_rom_loader
// Purpose  : Receives a framed byte stream from a host and writes the payload
//            into a code ROM. The frame is:
//              SOF(0xA5) LEN_HI LEN_LO payload[LEN] CSUM
//            The frame is good when the 8-bit sum of LEN_HI, LEN_LO, the
//            payload and CSUM is 0x00. The host can abort a frame, and a
//            stalled frame times out.
// Ports    : clk                clock (rising edge)
//            reset_code_rom_n   asynchronous active-low reset
//            in_data/in_valid   host byte stream
//            in_ready           byte is taken when in_valid && in_ready
//            abort              synchronous frame abort (honoured while busy)
//            code_rom_data_in   ROM write data (registered)
//            code_rom_addr_in   ROM write byte address (registered)
//            program_rom_mode   ROM write enable / address-mux select
//            busy               a frame is in progress
//            load_done          one-cycle pulse on a good frame
//            load_error         one-cycle pulse on a failed frame
//            err_code           0 abort, 1 bad length, 2 bad checksum,
//                               3 timeout; held until the next error
// Revision : 1.0 - initial release
// ============================================================================
module code_rom_loader #(
  parameter int MAX_BYTES      = 4096,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset_code_rom_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        abort,
  output logic [7:0]  code_rom_data_in,
  output logic [11:0] code_rom_addr_in,
  output logic        program_rom_mode,
  output logic        busy,
  output logic        load_done,
  output logic        load_error,
  output logic [1:0]  err_code
);

  localparam int          TW           = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [12:0] MAX_LEN      = 13'(MAX_BYTES);
  localparam logic [7:0]  SOF          = 8'hA5;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CSUM   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  logic [2:0]    state, next_state;
  logic [1:0]    next_err;
  logic [7:0]    len_hi;
  logic [11:0]   len;
  logic [11:0]   byte_cnt;
  logic [7:0]    sum;
  logic [TW-1:0] timer;

  logic          accept;
  logic          abort_hit;
  logic          timer_expiring;
  logic          timeout_hit;
  logic          last_byte;
  logic [12:0]   len_rx;
  logic          len_ok;

  // The timeout wins over a byte offered in the same cycle, so in_ready is
  // dropped on the expiring cycle as well as on an honoured abort.
  assign timer_expiring = busy && (timer == TIMEOUT_LAST);
  assign abort_hit      = busy && abort;
  assign timeout_hit    = timer_expiring && !abort;
  assign accept         = in_valid && in_ready;
  assign last_byte      = (byte_cnt == len - 12'd1);
  assign len_rx         = {1'b0, len_hi[3:0], in_data};
  assign len_ok         = (len_hi[7:4] == 4'd0) && (len_rx != 13'd0) &&
                          (len_rx <= MAX_LEN);

  // State register
  always_ff @(posedge clk or negedge reset_code_rom_n) begin
    if (!reset_code_rom_n) state <= S_IDLE;
    else                   state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    next_err   = err_code;
    case (state)
      S_IDLE:   if (accept && in_data == SOF) next_state = S_LEN_HI;
      S_LEN_HI: if (accept) next_state = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if (len_ok) begin
            next_state = S_DATA;
          end else begin
            next_state = S_ERR;
            next_err   = 2'd1;
          end
        end
      end
      S_DATA:   if (accept && last_byte) next_state = S_CSUM;
      S_CSUM: begin
        if (accept) begin
          if (8'(sum + in_data) == 8'h00) begin
            next_state = S_DONE;
          end else begin
            next_state = S_ERR;
            next_err   = 2'd2;
          end
        end
      end
      S_DONE:   next_state = S_IDLE;
      S_ERR:    next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
    if (timeout_hit) begin
      next_state = S_ERR;
      next_err   = 2'd3;
    end
    if (abort_hit) begin
      next_state = S_ERR;
      next_err   = 2'd0;
    end
  end

  // Output logic decoded from the state
  always_comb begin
    busy       = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                 (state == S_DATA)   || (state == S_CSUM);
    load_done  = (state == S_DONE);
    load_error = (state == S_ERR);
    in_ready   = (state != S_DONE) && (state != S_ERR) &&
                 !(busy && (abort || timer == TIMEOUT_LAST));
  end

  // Frame datapath: length, checksum, address counter, timeout, ROM port.
  always_ff @(posedge clk or negedge reset_code_rom_n) begin
    if (!reset_code_rom_n) begin
      len_hi           <= 8'd0;
      len              <= 12'd0;
      byte_cnt         <= 12'd0;
      sum              <= 8'd0;
      timer            <= '0;
      code_rom_data_in <= 8'd0;
      code_rom_addr_in <= 12'd0;
      program_rom_mode <= 1'b0;
      err_code         <= 2'd0;
    end else begin
      if (accept) begin
        case (state)
          S_IDLE:   sum <= 8'd0;
          S_LEN_HI: begin
            len_hi <= in_data;
            sum    <= sum + in_data;
          end
          S_LEN_LO: begin
            len      <= {len_hi[3:0], in_data};
            sum      <= sum + in_data;
            byte_cnt <= 12'd0;
          end
          S_DATA: begin
            sum              <= sum + in_data;
            code_rom_addr_in <= byte_cnt;
            code_rom_data_in <= in_data;
            // Stop on the last byte so the counter never passes LEN-1.
            if (!last_byte) byte_cnt <= byte_cnt + 12'd1;
          end
          default: ;
        endcase
      end

      if (!busy || accept) timer <= '0;
      else                 timer <= timer + 1'b1;

      // Write enable rises after the first payload byte and drops as soon
      // as the frame leaves DATA/CSUM.
      program_rom_mode <= ((next_state == S_DATA) || (next_state == S_CSUM)) &&
                          (program_rom_mode || (accept && state == S_DATA));

      if (next_state == S_ERR && state != S_ERR) err_code <= next_err;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_code_rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_code_rom_loader
// Purpose  : Self-checking bench for code_rom_loader (MAX_BYTES=8,
//            TIMEOUT_CYCLES=16). A vector table drives one byte per cycle and
//            compares in_ready (before the edge) and all registered/decoded
//            outputs (after the edge); hand sequences cover timeout, async
//            reset mid-frame and a back-pressured frame with leading garbage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_code_rom_loader;

  logic        clk = 1'b0;
  logic        reset_code_rom_n = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        abort = 1'b0;
  logic [7:0]  code_rom_data_in;
  logic [11:0] code_rom_addr_in;
  logic        program_rom_mode;
  logic        busy;
  logic        load_done;
  logic        load_error;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  code_rom_loader #(.MAX_BYTES(8), .TIMEOUT_CYCLES(16)) dut (
    .clk              (clk),
    .reset_code_rom_n (reset_code_rom_n),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .abort            (abort),
    .code_rom_data_in (code_rom_data_in),
    .code_rom_addr_in (code_rom_addr_in),
    .program_rom_mode (program_rom_mode),
    .busy             (busy),
    .load_done        (load_done),
    .load_error       (load_error),
    .err_code         (err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        ab;
    logic [26:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Write-side scoreboard used by the back-pressure sequence.
  logic       capture_en = 1'b0;
  logic [7:0] rom[4];
  logic [3:0] seen;
  int         wr_bad = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;

  always @(negedge clk) begin
    if (capture_en) begin
      if (program_rom_mode) begin
        if (code_rom_addr_in < 12'd4) begin
          rom[code_rom_addr_in[1:0]]  = code_rom_data_in;
          seen[code_rom_addr_in[1:0]] = 1'b1;
        end else begin
          wr_bad++;
        end
      end
      if (load_done)  done_cnt++;
      if (load_error) err_cnt++;
    end
  end

  function automatic logic [26:0] pk(input logic r, input logic m,
                                     input logic [11:0] a, input logic [7:0] dt,
                                     input logic b, input logic dn,
                                     input logic er, input logic [1:0] c);
    return {r, m, a, dt, b, dn, er, c};
  endfunction

  task automatic add(input logic v, input logic [7:0] d, input logic ab,
                     input logic r, input logic m, input logic [11:0] a,
                     input logic [7:0] dt, input logic b, input logic dn,
                     input logic er, input logic [1:0] c);
    vec_t x;
    x.v = v; x.d = d; x.ab = ab; x.exp = pk(r, m, a, dt, b, dn, er, c);
    tbl.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1: drive, sample in_ready, clock once, return at
  // posedge+1 with inputs released.
  task automatic step(input logic v, input logic [7:0] d, input logic ab,
                      output logic rdy);
    in_valid = v; in_data = d; abort = ab;
    #1 rdy = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0; abort = 1'b0; in_data = 8'd0;
  endtask

  function automatic logic [26:0] outs(input logic rdy);
    return {rdy, program_rom_mode, code_rom_addr_in, code_rom_data_in,
            busy, load_done, load_error, err_code};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rdy;
    logic early;
    logic [7:0] bp[10];

    // ------------------------------------------------------------ table
    //   v  d     ab  rdy mode addr   data  busy done err code
    // garbage in IDLE is discarded
    add(1, 8'h00, 0,  1, 0, 12'd0, 8'h00, 0, 0, 0, 2'd0);
    add(1, 8'hFF, 0,  1, 0, 12'd0, 8'h00, 0, 0, 0, 2'd0);
    // good frame A5 00 04 13 00 00 00 E9
    add(1, 8'hA5, 0,  1, 0, 12'd0, 8'h00, 1, 0, 0, 2'd0);
    add(1, 8'h00, 0,  1, 0, 12'd0, 8'h00, 1, 0, 0, 2'd0);
    add(1, 8'h04, 0,  1, 0, 12'd0, 8'h00, 1, 0, 0, 2'd0);
    add(1, 8'h13, 0,  1, 1, 12'd0, 8'h13, 1, 0, 0, 2'd0);
    add(1, 8'h00, 0,  1, 1, 12'd1, 8'h00, 1, 0, 0, 2'd0);
    add(1, 8'h00, 0,  1, 1, 12'd2, 8'h00, 1, 0, 0, 2'd0);
    add(1, 8'h00, 0,  1, 1, 12'd3, 8'h00, 1, 0, 0, 2'd0);
    add(1, 8'hE9, 0,  1, 0, 12'd3, 8'h00, 0, 1, 0, 2'd0);
    add(0, 8'h00, 0,  0, 0, 12'd3, 8'h00, 0, 0, 0, 2'd0);
    // same frame, bad checksum EA
    add(1, 8'hA5, 0,  1, 0, 12'd3, 8'h00, 1, 0, 0, 2'd0);
    add(1, 8'h00, 0,  1, 0, 12'd3, 8'h00, 1, 0, 0, 2'd0);
    add(1, 8'h04, 0,  1, 0, 12'd3, 8'h00, 1, 0, 0, 2'd0);
    add(1, 8'h13, 0,  1, 1, 12'd0, 8'h13, 1, 0, 0, 2'd0);
    add(1, 8'h00, 0,  1, 1, 12'd1, 8'h00, 1, 0, 0, 2'd0);
    add(1, 8'h00, 0,  1, 1, 12'd2, 8'h00, 1, 0, 0, 2'd0);
    add(1, 8'h00, 0,  1, 1, 12'd3, 8'h00, 1, 0, 0, 2'd0);
    add(1, 8'hEA, 0,  1, 0, 12'd3, 8'h00, 0, 0, 1, 2'd2);
    add(0, 8'h00, 0,  0, 0, 12'd3, 8'h00, 0, 0, 0, 2'd2);
    // bad length: LEN_HI upper nibble set
    add(1, 8'hA5, 0,  1, 0, 12'd3, 8'h00, 1, 0, 0, 2'd2);
    add(1, 8'h10, 0,  1, 0, 12'd3, 8'h00, 1, 0, 0, 2'd2);
    add(1, 8'h01, 0,  1, 0, 12'd3, 8'h00, 0, 0, 1, 2'd1);
    add(0, 8'h00, 0,  0, 0, 12'd3, 8'h00, 0, 0, 0, 2'd1);
    // bad length: zero
    add(1, 8'hA5, 0,  1, 0, 12'd3, 8'h00, 1, 0, 0, 2'd1);
    add(1, 8'h00, 0,  1, 0, 12'd3, 8'h00, 1, 0, 0, 2'd1);
    add(1, 8'h00, 0,  1, 0, 12'd3, 8'h00, 0, 0, 1, 2'd1);
    add(0, 8'h00, 0,  0, 0, 12'd3, 8'h00, 0, 0, 0, 2'd1);
    // bad length: MAX_BYTES+1
    add(1, 8'hA5, 0,  1, 0, 12'd3, 8'h00, 1, 0, 0, 2'd1);
    add(1, 8'h00, 0,  1, 0, 12'd3, 8'h00, 1, 0, 0, 2'd1);
    add(1, 8'h09, 0,  1, 0, 12'd3, 8'h00, 0, 0, 1, 2'd1);
    add(0, 8'h00, 0,  0, 0, 12'd3, 8'h00, 0, 0, 0, 2'd1);
    // abort ignored in IDLE; LEN=MAX_BYTES accepted; abort after 2 bytes
    // beats a byte offered in the same cycle
    add(1, 8'hA5, 1,  1, 0, 12'd3, 8'h00, 1, 0, 0, 2'd1);
    add(1, 8'h00, 0,  1, 0, 12'd3, 8'h00, 1, 0, 0, 2'd1);
    add(1, 8'h08, 0,  1, 0, 12'd3, 8'h00, 1, 0, 0, 2'd1);
    add(1, 8'h11, 0,  1, 1, 12'd0, 8'h11, 1, 0, 0, 2'd1);
    add(1, 8'h22, 0,  1, 1, 12'd1, 8'h22, 1, 0, 0, 2'd1);
    add(1, 8'h33, 1,  0, 0, 12'd1, 8'h22, 0, 0, 1, 2'd0);
    add(0, 8'h00, 0,  0, 0, 12'd1, 8'h22, 0, 0, 0, 2'd0);
    add(0, 8'h00, 1,  1, 0, 12'd1, 8'h22, 0, 0, 0, 2'd0);
    // LEN=1 with a payload byte equal to SOF; checksum 5A
    add(1, 8'hA5, 0,  1, 0, 12'd1, 8'h22, 1, 0, 0, 2'd0);
    add(1, 8'h00, 0,  1, 0, 12'd1, 8'h22, 1, 0, 0, 2'd0);
    add(1, 8'h01, 0,  1, 0, 12'd1, 8'h22, 1, 0, 0, 2'd0);
    add(1, 8'hA5, 0,  1, 1, 12'd0, 8'hA5, 1, 0, 0, 2'd0);
    add(1, 8'h5A, 0,  1, 0, 12'd0, 8'hA5, 0, 1, 0, 2'd0);
    add(0, 8'h00, 0,  0, 0, 12'd0, 8'hA5, 0, 0, 0, 2'd0);

    // ------------------------------------------------------------ reset
    #3;
    chk("reset_outputs",
        {program_rom_mode, code_rom_addr_in, code_rom_data_in, busy,
         load_done, load_error, err_code}, 32'd0);
    @(posedge clk); #2 reset_code_rom_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_ready", in_ready, 1);
    chk("post_reset_no_write", program_rom_mode, 0);

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, tbl[i].ab, rdy);
      chk($sformatf("vec%0d", i), outs(rdy), tbl[i].exp);
    end

    // ------------------------------------------------------------ timeout
    // ERR must be entered on the clock edge that ends the 16th idle cycle
    // after the last accepted byte.
    step(1, 8'hA5, 0, rdy); step(1, 8'h00, 0, rdy);
    step(1, 8'h02, 0, rdy); step(1, 8'hAA, 0, rdy);
    chk("stall_write", {program_rom_mode, code_rom_addr_in, code_rom_data_in},
        {1'b1, 12'd0, 8'hAA});
    early = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      step(0, 8'h00, 0, rdy);
      if (load_error || !busy) early = 1'b1;
    end
    chk("timeout_not_early", early, 0);
    chk("stall_hold", {program_rom_mode, code_rom_addr_in, code_rom_data_in},
        {1'b1, 12'd0, 8'hAA});
    step(0, 8'h00, 0, rdy);
    chk("timeout_err", {load_error, err_code, busy, program_rom_mode},
        {1'b1, 2'd3, 1'b0, 1'b0});
    step(0, 8'h00, 0, rdy);
    chk("timeout_idle", {load_error, busy, in_ready}, {1'b0, 1'b0, 1'b1});

    // ------------------------------------------------------------ async reset mid-frame
    step(1, 8'hA5, 0, rdy); step(1, 8'h00, 0, rdy);
    step(1, 8'h02, 0, rdy); step(1, 8'h11, 0, rdy);
    chk("pre_reset_state", {program_rom_mode, busy, err_code},
        {1'b1, 1'b1, 2'd3});
    #2 reset_code_rom_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        {program_rom_mode, code_rom_addr_in, code_rom_data_in, busy,
         load_done, load_error, err_code}, 32'd0);
    @(posedge clk); @(posedge clk); #2 reset_code_rom_n = 1'b1;
    @(posedge clk); #1;
    chk("release_ready_nowrite", {in_ready, program_rom_mode, busy},
        {1'b1, 1'b0, 1'b0});

    // ------------------------------------------------------------ back-pressure
    bp = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h04, 8'h13, 8'h00, 8'h00, 8'h00, 8'hE9};
    seen = 4'b0000;
    for (int i = 0; i < 4; i++) rom[i] = 8'h5C;
    capture_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 3)) step(0, 8'h00, 0, rdy);
      step(1, bp[i], 0, rdy);
    end
    step(0, 8'h00, 0, rdy);
    step(0, 8'h00, 0, rdy);
    capture_en = 1'b0;
    chk("bp_seen", seen, 4'b1111);
    chk("bp_rom0", rom[0], 8'h13);
    chk("bp_rom1", rom[1], 8'h00);
    chk("bp_rom2", rom[2], 8'h00);
    chk("bp_rom3", rom[3], 8'h00);
    chk("bp_stray_writes", wr_bad, 0);
    chk("bp_done_pulses", done_cnt, 1);
    chk("bp_error_pulses", err_cnt, 0);
    chk("bp_final", {busy, program_rom_mode}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
